// File: rtl/gx_link_pkg.sv
// Shared line coding for the GX framed link: code words, K-flag patterns, framer states.
// Latency: none, definitions only.
// Backpressure: none here; the framer and deframer apply their own flow control.
package gx_link_pkg;

  // One transceiver parallel word: per-byte K flags plus the 16-bit data.
  typedef struct packed {
    logic [1:0]  ctrl;
    logic [15:0] dat;
  } gx_word_t;

  // K-flag patterns; bit [1] covers dat[15:8].
  localparam logic [1:0] GX_CTRL_DATA = 2'b00;
  localparam logic [1:0] GX_CTRL_KHI  = 2'b10;
  localparam logic [1:0] GX_CTRL_KK   = 2'b11;

  // Code word data values.
  localparam logic [15:0] GX_IDLE_DAT = 16'hBC50;
  localparam logic [15:0] GX_SOF_DAT  = 16'hFB00;
  localparam logic [15:0] GX_EOF_DAT  = 16'hFD00;
  localparam logic [15:0] GX_FILL_DAT = 16'h1C1C;

  // Complete code words as they appear on the TX interface.
  localparam gx_word_t GX_IDLE_W = '{ctrl: GX_CTRL_KHI, dat: GX_IDLE_DAT};
  localparam gx_word_t GX_SOF_W  = '{ctrl: GX_CTRL_KHI, dat: GX_SOF_DAT};
  localparam gx_word_t GX_EOF_W  = '{ctrl: GX_CTRL_KHI, dat: GX_EOF_DAT};
  localparam gx_word_t GX_FILL_W = '{ctrl: GX_CTRL_KK,  dat: GX_FILL_DAT};

  // Framer states; the deframer tracks the same frame phases.
  typedef enum logic [2:0] {
    GX_ST_IDLE    = 3'd0,
    GX_ST_SOF     = 3'd1,
    GX_ST_PAYLOAD = 3'd2,
    GX_ST_CSUM    = 3'd3,
    GX_ST_EOF     = 3'd4,
    GX_ST_DROP    = 3'd5
  } gx_state_e;

  // Wrap a payload or checksum value as a plain data word (no K flags).
  function automatic gx_word_t gx_data_word(input logic [15:0] dat);
    gx_word_t w;
    w.ctrl = GX_CTRL_DATA;
    w.dat  = dat;
    return w;
  endfunction

endpackage

// File: rtl/gx_tx_framer.sv
// Frames a valid/ready payload stream into SOF/payload/checksum/EOF words for a transceiver TX lane.
// Latency: accepted payload word reaches tx_datain one cycle after acceptance; SOF/CSUM/EOF one cycle after their state.
// Backpressure: s_ready only in PAYLOAD/DROP with tx_ready high; FILL words pad payload gaps, IDLE pads DROP.
module gx_tx_framer
  import gx_link_pkg::*;
#(
  parameter int unsigned IDLE_GAP = 4,
  parameter int unsigned MAX_LEN  = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tx_ready,
  input  logic        s_valid,
  input  logic [15:0] s_data,
  input  logic        s_last,
  output logic        s_ready,
  output logic [15:0] tx_datain,
  output logic [1:0]  tx_ctrlenable,
  output logic        tx_busy,
  output logic        err_trunc
);

  // Word counter must hold MAX_LEN itself.
  localparam int unsigned CNT_W = $clog2(MAX_LEN + 1);
  localparam logic [7:0] GAP_FULL = 8'(IDLE_GAP);
  // Counter value while the MAX_LEN-th word is being accepted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_LEN - 1);

  gx_state_e        state_q, state_d;
  logic [7:0]       gap_q, gap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      csum_q, csum_d;
  logic             trunc_q, trunc_d;
  logic             err_q, err_d;
  gx_word_t         out_q, out_d;

  logic             accept;
  logic [7:0]       gap_inc;

  // Payload is only taken while a frame body or a discard is in progress and the lane is up.
  always_comb begin
    s_ready = tx_ready && (state_q == GX_ST_PAYLOAD || state_q == GX_ST_DROP);
    accept  = s_valid && s_ready;
  end

  // Next state, counters, checksum and the word to register onto the lane.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    cnt_d   = cnt_q;
    csum_d  = csum_q;
    trunc_d = trunc_q;
    err_d   = 1'b0;
    out_d   = GX_IDLE_W;
    // The IDLE word emitted this cycle already counts toward the gap.
    gap_inc = (gap_q == GAP_FULL) ? gap_q : gap_q + 8'd1;

    case (state_q)
      GX_ST_IDLE: begin
        out_d = GX_IDLE_W;
        gap_d = gap_inc;
        // A pending word is required, so zero-length frames cannot be started.
        if (tx_ready && s_valid && gap_inc == GAP_FULL) begin
          state_d = GX_ST_SOF;
        end
      end

      GX_ST_SOF: begin
        out_d   = GX_SOF_W;
        cnt_d   = '0;
        csum_d  = '0;
        trunc_d = 1'b0;
        state_d = GX_ST_PAYLOAD;
      end

      GX_ST_PAYLOAD: begin
        out_d = GX_FILL_W;
        if (accept) begin
          out_d  = gx_data_word(s_data);
          csum_d = csum_q + s_data;
          cnt_d  = cnt_q + CNT_W'(1);
          if (s_last) begin
            state_d = GX_ST_CSUM;
          end else if (cnt_q == CNT_LAST) begin
            // Frame hit MAX_LEN without a last marker: close it cleanly, discard the remainder.
            state_d = GX_ST_CSUM;
            trunc_d = 1'b1;
            err_d   = 1'b1;
          end
        end
      end

      GX_ST_CSUM: begin
        out_d   = gx_data_word(csum_q);
        state_d = GX_ST_EOF;
      end

      GX_ST_EOF: begin
        out_d   = GX_EOF_W;
        gap_d   = '0;
        state_d = trunc_q ? GX_ST_DROP : GX_ST_IDLE;
      end

      GX_ST_DROP: begin
        out_d = GX_IDLE_W;
        if (accept && s_last) begin
          state_d = GX_ST_IDLE;
          gap_d   = '0;
          trunc_d = 1'b0;
        end
      end

      default: begin
        state_d = GX_ST_IDLE;
        gap_d   = '0;
      end
    endcase
  end

  // State and datapath registers; reset abandons any frame in flight without an EOF.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= GX_ST_IDLE;
      gap_q   <= '0;
      cnt_q   <= '0;
      csum_q  <= '0;
      trunc_q <= 1'b0;
      err_q   <= 1'b0;
      out_q   <= GX_IDLE_W;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      cnt_q   <= cnt_d;
      csum_q  <= csum_d;
      trunc_q <= trunc_d;
      err_q   <= err_d;
      out_q   <= out_d;
    end
  end

  // Registered lane outputs and status.
  always_comb begin
    tx_datain     = out_q.dat;
    tx_ctrlenable = out_q.ctrl;
    tx_busy       = (state_q != GX_ST_IDLE);
    err_trunc     = err_q;
  end

endmodule

// File: tb/tb_gx_tx_framer.sv
// Scoreboard bench for gx_tx_framer: a frame-level model queues the expected line words per offered frame.
// Latency: monitor samples the line every falling edge and pops one expected word per non-IDLE, non-FILL word.
// Backpressure: driver inserts s_valid bubbles and tx_ready drops; FILL counts and gaps are checked separately.
module tb_gx_tx_framer;

  localparam int IDLE_GAP = 4;
  localparam int MAX_LEN  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tx_ready = 1'b0;
  logic        s_valid = 1'b0;
  logic [15:0] s_data = 16'h0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic [15:0] tx_datain;
  logic [1:0]  tx_ctrlenable;
  logic        tx_busy;
  logic        err_trunc;

  gx_tx_framer #(.IDLE_GAP(IDLE_GAP), .MAX_LEN(MAX_LEN)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tx_ready     (tx_ready),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_last       (s_last),
    .s_ready      (s_ready),
    .tx_datain    (tx_datain),
    .tx_ctrlenable(tx_ctrlenable),
    .tx_busy      (tx_busy),
    .err_trunc    (err_trunc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  ctrl;
    logic [15:0] dat;
    logic        trunc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e_mon;
  int          checks = 0;
  int          errors = 0;
  int          fill_cnt = 0;
  int          fill_exp = 0;
  int          err_cnt = 0;
  int          idle_run = 0;
  int          last_gap = -1;
  logic [15:0] frm [0:15];
  int          frm_n;
  int          bub [0:15];
  int          drp [0:15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: classify each line word and compare framed words against the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      idle_run = 0;
    end else begin
      if (err_trunc) err_cnt++;
      if (tx_ctrlenable == 2'b10 && tx_datain == 16'hBC50) begin
        idle_run++;
        chk("err_trunc_on_idle", 32'(err_trunc), 32'd0);
      end else if (tx_ctrlenable == 2'b11) begin
        fill_cnt++;
        chk("fill_data", 32'(tx_datain), 32'h1C1C);
        chk("busy_on_fill", 32'(tx_busy), 32'd1);
      end else if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got ctrl %b data %h, required no framed word at %0t",
                 tx_ctrlenable, tx_datain, $time);
      end else begin
        e_mon = exp_q.pop_front();
        chk("line_word", {14'b0, tx_ctrlenable, tx_datain}, {14'b0, e_mon.ctrl, e_mon.dat});
        chk("err_trunc", 32'(err_trunc), 32'(e_mon.trunc));
        if (e_mon.ctrl == 2'b00 || (e_mon.ctrl == 2'b10 && e_mon.dat == 16'hFB00))
          chk("busy_in_frame", 32'(tx_busy), 32'd1);
        if (e_mon.ctrl == 2'b10 && e_mon.dat == 16'hFB00) begin
          chk("idle_gap_min", 32'(idle_run >= IDLE_GAP), 32'd1);
          last_gap = idle_run;
        end
        idle_run = 0;
      end
    end
  end

  // Reference model: the line image of one offered frame, from the framing rules.
  task automatic model_frame();
    logic [15:0] sum;
    int m;
    exp_t e;
    sum = 16'h0;
    m = (frm_n < MAX_LEN) ? frm_n : MAX_LEN;
    e = '{ctrl: 2'b10, dat: 16'hFB00, trunc: 1'b0};
    exp_q.push_back(e);
    for (int i = 0; i < m; i++) begin
      sum = sum + frm[i];
      e = '{ctrl: 2'b00, dat: frm[i], trunc: (i == MAX_LEN - 1 && frm_n > MAX_LEN)};
      exp_q.push_back(e);
    end
    e = '{ctrl: 2'b00, dat: sum, trunc: 1'b0};
    exp_q.push_back(e);
    e = '{ctrl: 2'b10, dat: 16'hFD00, trunc: 1'b0};
    exp_q.push_back(e);
  endtask

  task automatic clr();
    for (int i = 0; i < 16; i++) begin
      bub[i] = 0;
      drp[i] = 0;
    end
  endtask

  // Driver: offers frm[0..frm_n-1]; abort_after>0 asserts reset once that many words are accepted.
  task automatic send_frame(input int abort_after);
    int m;
    bit acc;
    m = (frm_n < MAX_LEN) ? frm_n : MAX_LEN;
    model_frame();
    for (int i = 0; i < frm_n; i++) begin
      if (i >= 1 && i < m && bub[i] > 0) begin
        s_valid = 1'b0;
        repeat (bub[i]) @(posedge clk);
        #1;
        fill_exp += bub[i];
      end
      s_valid = 1'b1;
      s_data  = frm[i];
      s_last  = (i == frm_n - 1);
      if (i >= 1 && i < m && drp[i] > 0) begin
        tx_ready = 1'b0;
        for (int c = 0; c < drp[i]; c++) begin
          @(negedge clk);
          chk("s_ready_lane_down", 32'(s_ready), 32'd0);
          @(posedge clk);
          #1;
        end
        tx_ready = 1'b1;
        fill_exp += drp[i];
      end
      acc = 1'b0;
      for (int c = 0; c < 200 && !acc; c++) begin
        @(negedge clk);
        acc = s_ready;
        @(posedge clk);
        #1;
      end
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: word %0d never accepted, required acceptance within 200 cycles", i);
      end
      if (abort_after == i + 1) begin
        s_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        break;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 100) begin
      @(posedge clk);
      c++;
    end
    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    int e0;
    // Reset state.
    rst_n = 1'b0;
    tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_datain", 32'(tx_datain), 32'hBC50);
    chk("rst_ctrl", 32'(tx_ctrlenable), 32'd2);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_err", 32'(err_trunc), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    // Basic frame, checksum 0006.
    clr();
    frm_n = 3; frm[0] = 16'h0001; frm[1] = 16'h0002; frm[2] = 16'h0003;
    send_frame(0);
    drain();

    // Checksum wrap-around: FFFF + 0002 = 0001.
    clr();
    frm_n = 2; frm[0] = 16'hFFFF; frm[1] = 16'h0002;
    send_frame(0);
    drain();

    // Two-cycle s_valid bubble mid-frame; frame of exactly MAX_LEN with last.
    clr();
    frm_n = 4; frm[0] = 16'h0010; frm[1] = 16'h0020; frm[2] = 16'h0030; frm[3] = 16'h0040;
    bub[2] = 2;
    f0 = fill_cnt;
    send_frame(0);
    drain();
    chk("fill_after_bubble", 32'(fill_cnt - f0), 32'd2);

    // Truncation: six words with MAX_LEN four, then a normal frame.
    clr();
    frm_n = 6;
    for (int i = 0; i < 6; i++) frm[i] = 16'(i + 1);
    e0 = err_cnt;
    send_frame(0);
    frm_n = 1; frm[0] = 16'h00AA;
    send_frame(0);
    drain();
    chk("err_trunc_pulses", 32'(err_cnt - e0), 32'd1);

    // Lane down three cycles mid-payload.
    clr();
    frm_n = 3; frm[0] = 16'h0A0A; frm[1] = 16'h0B0B; frm[2] = 16'h0C0C;
    drp[1] = 3;
    f0 = fill_cnt;
    send_frame(0);
    drain();
    chk("fill_after_lane_drop", 32'(fill_cnt - f0), 32'd3);

    // Back-to-back frames: exactly IDLE_GAP idles between EOF and SOF.
    clr();
    frm_n = 2; frm[0] = 16'h0005; frm[1] = 16'h0006;
    send_frame(0);
    frm_n = 1; frm[0] = 16'h0007;
    send_frame(0);
    chk("gap_back_to_back", 32'(last_gap), 32'(IDLE_GAP));
    drain();

    // Reset mid-payload: immediate idle outputs, then a clean frame.
    clr();
    frm_n = 4; frm[0] = 16'h1111; frm[1] = 16'h2222; frm[2] = 16'h3333; frm[3] = 16'h4444;
    send_frame(2);
    #1;
    chk("midrst_datain", 32'(tx_datain), 32'hBC50);
    chk("midrst_ctrl", 32'(tx_ctrlenable), 32'd2);
    chk("midrst_busy", 32'(tx_busy), 32'd0);
    chk("midrst_err", 32'(err_trunc), 32'd0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    frm_n = 2; frm[0] = 16'h0100; frm[1] = 16'h0200;
    send_frame(0);
    drain();

    // Randomized frames with bubbles, lane drops and truncation.
    for (int f = 0; f < 40; f++) begin
      clr();
      frm_n = int'($urandom_range(1, 7));
      for (int i = 0; i < frm_n; i++) begin
        frm[i] = 16'($urandom);
        bub[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
        drp[i] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
      end
      send_frame(0);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 8)) @(posedge clk);
        #1;
      end
    end
    drain();
    repeat (4) @(posedge clk);
    #1;
    chk("fill_total", 32'(fill_cnt), 32'(fill_exp));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gx_tx_framer.md
GX_TX_FRAMER -- requirements
Module: gx_tx_framer

Interface
REQ-001 Parameter IDLE_GAP, default 4, minimum idle words between EOF and next SOF (range 1..255).
REQ-002 Parameter MAX_LEN, default 256, maximum payload words per frame (range 1..1024).
REQ-003 clk  input  1  single clock, transceiver TX parallel clock domain; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 tx_ready  input  1  high when the transceiver PLL is locked and TX digital reset is released.
REQ-006 s_valid  input  1  payload word valid.
REQ-007 s_data  input  16  payload word.
REQ-008 s_last  input  1  marks last payload word of a frame.
REQ-009 s_ready  output  1  payload word accepted on the same cycle when s_valid && s_ready.
REQ-010 tx_datain  output  16  parallel word to transceiver TX, registered.
REQ-011 tx_ctrlenable  output  2  per-byte K-character flags, [1] for tx_datain[15:8], registered.
REQ-012 tx_busy  output  1  high while state is not IDLE.
REQ-013 err_trunc  output  1  one-cycle pulse when a frame is truncated at MAX_LEN.

Function
REQ-014 Code words: IDLE=16'hBC50/ctrl 2'b10; SOF=16'hFB00/ctrl 2'b10; EOF=16'hFD00/ctrl 2'b10; FILL=16'h1C1C/ctrl 2'b11; payload and checksum use ctrl 2'b00.
REQ-015 States: IDLE, SOF, PAYLOAD, CSUM, EOF, DROP.
REQ-016 IDLE: emit IDLE word each cycle; gap counter increments (saturating at IDLE_GAP).
REQ-017 IDLE -> SOF when tx_ready && s_valid && gap counter == IDLE_GAP; SOF word appears on tx_datain the next cycle.
REQ-018 SOF -> PAYLOAD unconditionally after one cycle; s_ready is low in SOF.
REQ-019 s_ready = tx_ready && (state == PAYLOAD || state == DROP), combinational.
REQ-020 PAYLOAD: accepted word appears on tx_datain exactly one cycle after acceptance; a cycle without acceptance emits FILL.
REQ-021 Checksum = 16-bit sum, modulo 2^16, of all payload words transmitted in the frame; cleared at SOF.
REQ-022 PAYLOAD -> CSUM on acceptance with s_last, or on acceptance of word number MAX_LEN.
REQ-023 Word MAX_LEN accepted without s_last: pulse err_trunc once, send CSUM and EOF, then enter DROP.
REQ-024 DROP: accept and discard words, emit IDLE, until a word with s_last is accepted, then -> IDLE with gap counter 0.
REQ-025 CSUM emits the checksum for one cycle; EOF emits EOF for one cycle; EOF -> IDLE (or DROP per REQ-023) with gap counter cleared to 0.
REQ-026 s_last on word MAX_LEN: normal termination, no err_trunc, no DROP.
REQ-027 tx_ready low in PAYLOAD/DROP: state held, s_ready low, PAYLOAD emits FILL, DROP emits IDLE; in SOF/CSUM/EOF the state still advances.
REQ-028 tx_ready low in IDLE: no frame start; IDLE words continue; gap counter still counts.
REQ-029 Payload word counter width ceil(log2(MAX_LEN+1)); zero-length frames are impossible (SOF requires a pending word).

Reset
REQ-030 While rst_n is low: state IDLE, tx_datain 16'hBC50, tx_ctrlenable 2'b10, tx_busy 0, err_trunc 0, checksum 0, word counter 0, gap counter 0.
REQ-031 Reset mid-frame abandons the frame; no EOF is sent; the first SOF after release waits IDLE_GAP idle cycles.

Structure
REQ-032 The code words, ctrl patterns and state encoding are kept in a shared package, gx_link_pkg, for reuse by the matching receive deframer.
REQ-033 Single module, no sub-modules; the checksum accumulator is inline.

Verification
REQ-034 Reset released, tx_ready=1, frame {16'h0001,16'h0002,16'h0003 last} offered: 4 IDLE words, then SOF, 0001, 0002, 0003, checksum 16'h0006, EOF, IDLE.
REQ-035 Payload 16'hFFFF,16'h0002 last: checksum word 16'h0001 (wrap-around).
REQ-036 s_valid deasserted 2 cycles mid-frame: two FILL words (16'h1C1C, ctrl 2'b11) inserted; checksum unaffected.
REQ-037 MAX_LEN=4, 6-word frame: 4 payload words, CSUM, EOF, one err_trunc pulse, words 5-6 discarded, next frame SOF ≥ IDLE_GAP idles after EOF.
REQ-038 tx_ready dropped 3 cycles in PAYLOAD: s_ready low, 3 FILL words, frame resumes intact; back-to-back frames separated by exactly IDLE_GAP IDLE words.
REQ-039 rst_n asserted mid-payload: outputs immediately IDLE/2'b10, tx_busy 0; after release next frame sends correct checksum.
